// File: rtl/bus_trace_capture.sv
// Passive 6502 bus trace unit: arms on request, waits for an optional opcode-fetch
// address trigger, then buffers {stamp, addr, data, rw_n, sync} records in a FWFT FIFO.
module bus_trace_capture #(
  parameter int DEPTH        = 16,
  parameter int POST_COUNT   = 64,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [15:0]              trig_addr,
  input  logic [15:0]              bus_addr,
  input  logic [7:0]               bus_data,
  input  logic                     bus_rw_n,
  input  logic                     bus_sync,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [41:0]              rec_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               overflow_cnt,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(POST_COUNT + 2);
  localparam logic [PW-1:0] POST_LIM = PW'(POST_COUNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_STOPPED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   stamp_q, stamp_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [PW-1:0] post_q, post_d;
  logic [41:0]   mem_q [DEPTH];

  logic        push, pop, full, trig_hit, capture_hit, counted;
  logic [41:0] rec_word;

  assign full        = (level_q == LW'(DEPTH));
  assign trig_hit    = !trig_en || (bus_sync && (bus_addr == trig_addr));
  assign capture_hit = sample_en &&
                       (((state_q == S_ARMED) && trig_hit) || (state_q == S_CAPTURE));
  // Stamp is always 0 while ARMED, so the triggering record naturally gets stamp 0.
  assign rec_word    = {stamp_q, bus_addr, bus_data, bus_rw_n, bus_sync};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    stamp_d  = stamp_q;
    ovf_d    = ovf_q;
    post_d   = post_q;
    push     = 1'b0;
    counted  = 1'b0;
    pop      = rec_valid && rec_ready;

    if (arm) begin
      // arm beats stop and discards any pop presented in the same cycle.
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      stamp_d  = '0;
      ovf_d    = '0;
      post_d   = '0;
      pop      = 1'b0;
    end else begin
      if (stop) begin
        state_d = S_STOPPED;
      end else if (capture_hit) begin
        stamp_d = stamp_q + 16'd1;
        if (state_q == S_ARMED) state_d = S_CAPTURE;
        if (full && !pop) begin
          if (STOP_ON_FULL) begin
            state_d = S_STOPPED;
          end else begin
            counted = 1'b1;
            if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
          end
        end else begin
          push    = 1'b1;
          counted = 1'b1;
        end
        // Dropped records still consume the post-trigger budget.
        if (counted) begin
          post_d = post_q + PW'(1);
          if ((POST_COUNT != 0) && (post_d == POST_LIM)) state_d = S_STOPPED;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      stamp_q  <= '0;
      ovf_q    <= '0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      stamp_q  <= stamp_d;
      ovf_q    <= ovf_d;
      post_q   <= post_d;
    end
  end

  // NOTE: record storage is deliberately not reset; the level gate on rec_data hides stale words.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_word;
  end

  assign rec_valid    = (level_q != '0);
  assign rec_data     = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = (state_q == S_STOPPED);

endmodule

// File: tb/tb_bus_trace_capture.sv
// Bench for bus_trace_capture: four parameter variants share one stimulus stream and
// are checked every cycle against a queue-level model, plus directed scenario checks.
module tb_bus_trace_capture;

  localparam int NI = 4;
  localparam int PC [NI]  = '{64, 0, 3, 0};
  localparam bit SOF [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset, sample_en, arm, stop, trig_en, rec_ready;
  logic [15:0] trig_addr, bus_addr;
  logic [7:0]  bus_data;
  logic        bus_rw_n, bus_sync;

  logic        vld  [NI];
  logic [41:0] rdat [NI];
  logic [4:0]  lvl  [NI];
  logic [7:0]  ovf  [NI];
  logic [1:0]  st   [NI];
  logic        dn   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_trace_capture #(.DEPTH(16), .POST_COUNT(PC[g]), .STOP_ON_FULL(SOF[g])) u_dut (
      .clk(clk), .reset(reset), .sample_en(sample_en), .arm(arm), .stop(stop),
      .trig_en(trig_en), .trig_addr(trig_addr), .bus_addr(bus_addr),
      .bus_data(bus_data), .bus_rw_n(bus_rw_n), .bus_sync(bus_sync),
      .rec_valid(vld[g]), .rec_ready(rec_ready), .rec_data(rdat[g]),
      .level(lvl[g]), .overflow_cnt(ovf[g]), .state(st[g]), .done(dn[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // Reference model: head-at-index-0 record list per instance, mode as an integer.
  logic [41:0] m_fifo  [NI][16];
  int          m_cnt   [NI];
  int          m_mode  [NI];   // 0 idle, 1 armed, 2 capturing, 3 stopped
  logic [15:0] m_stamp [NI];
  int          m_ovf   [NI];
  int          m_posted[NI];

  task automatic m_clear(input int i);
    m_cnt[i] = 0; m_stamp[i] = 16'h0; m_ovf[i] = 0; m_posted[i] = 0;
  endtask

  task automatic m_step(input int i);
    bit          take, room, wr;
    logic [41:0] word;
    if (reset) begin
      m_clear(i); m_mode[i] = 0;
    end else if (arm) begin
      m_clear(i); m_mode[i] = 1;
    end else begin
      take = (m_cnt[i] > 0) && rec_ready;
      room = (m_cnt[i] < 16) || take;
      wr   = 1'b0;
      word = {m_stamp[i], bus_addr, bus_data, bus_rw_n, bus_sync};
      if (stop) begin
        m_mode[i] = 3;
      end else if (sample_en && (m_mode[i] == 2 || (m_mode[i] == 1 &&
                   (!trig_en || (bus_sync && bus_addr == trig_addr))))) begin
        m_mode[i]  = 2;
        m_stamp[i] = m_stamp[i] + 16'd1;
        if (room) begin
          wr = 1'b1; m_posted[i]++;
        end else if (SOF[i]) begin
          m_mode[i] = 3;
        end else begin
          m_posted[i]++;
          if (m_ovf[i] < 255) m_ovf[i]++;
        end
        if (PC[i] != 0 && m_posted[i] == PC[i]) m_mode[i] = 3;
      end
      if (take) begin
        for (int k = 0; k < 15; k++) m_fifo[i][k] = m_fifo[i][k+1];
        m_cnt[i]--;
      end
      if (wr) begin
        m_fifo[i][m_cnt[i]] = word;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d.state", i), st[i], m_mode[i]);
      check($sformatf("i%0d.level", i), lvl[i], m_cnt[i]);
      check($sformatf("i%0d.ovf", i), ovf[i], m_ovf[i]);
      check($sformatf("i%0d.valid", i), vld[i], m_cnt[i] > 0);
      check($sformatf("i%0d.done", i), dn[i], m_mode[i] == 3);
      if (m_cnt[i] > 0) check($sformatf("i%0d.data", i), rdat[i], m_fifo[i][0]);
    end
  endtask

  logic [41:0] got [$];

  // One clock: log the instance-0 pop about to happen, advance model at the edge, compare mid-cycle.
  task automatic tick();
    if (!reset && !arm && rec_ready && vld[0]) got.push_back(rdat[0]);
    @(posedge clk);
    for (int i = 0; i < NI; i++) m_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic bus(input logic [15:0] a, input logic s);
    sample_en = 1'b1; bus_addr = a; bus_sync = s;
    bus_data = 8'($urandom); bus_rw_n = 1'($urandom);
    tick();
    sample_en = 1'b0;
    tick();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [15:0] t1_addr [5];
  logic [7:0]  t1_data [5];
  int          hi_ready;

  initial begin
    reset = 1'b1; sample_en = 1'b0; arm = 1'b0; stop = 1'b0; trig_en = 1'b0;
    rec_ready = 1'b0; trig_addr = 16'h0210; bus_addr = 16'h0; bus_data = 8'h0;
    bus_rw_n = 1'b1; bus_sync = 1'b0;
    for (int i = 0; i < NI; i++) begin m_clear(i); m_mode[i] = 0; end
    run(2);
    check("rst.state", st[0], 2'd0);
    check("rst.data", rdat[0], 42'h0);
    reset = 1'b0;
    run(2);

    // T1: free-running trigger, five records drained in order.
    trig_en = 1'b0; rec_ready = 1'b1; got.delete();
    pulse_arm();
    for (int k = 0; k < 5; k++) begin
      bus(16'h0200 + 16'(k), 1'b1);
      t1_addr[k] = bus_addr; t1_data[k] = bus_data;
    end
    run(3);
    check("t1.count", got.size(), 5);
    for (int k = 0; k < 5; k++) if (k < got.size()) begin
      check($sformatf("t1.stamp%0d", k), got[k][41:26], k);
      check($sformatf("t1.addr%0d", k), got[k][25:10], t1_addr[k]);
      check($sformatf("t1.data%0d", k), got[k][9:2], t1_data[k]);
    end
    pulse_stop();

    // T2: address trigger on an opcode fetch only.
    trig_en = 1'b1; got.delete();
    pulse_arm();
    bus(16'h0200, 1'b1);
    check("t2.armed_a", st[0], 2'd1);
    bus(16'h0210, 1'b0);
    check("t2.armed_nosync", st[0], 2'd1);
    bus(16'h0210, 1'b1);
    check("t2.capture", st[0], 2'd2);
    for (int k = 0; k < 3; k++) bus(16'h0220 + 16'(k), 1'b0);
    run(3);
    check("t2.count", got.size(), 4);
    if (got.size() > 3) begin
      check("t2.addr0", got[0][25:10], 16'h0210);
      check("t2.stamp0", got[0][41:26], 16'h0);
      check("t2.stamp3", got[3][41:26], 16'h3);
    end
    pulse_stop();

    // T3/T4/T5a: 20 back-to-back samples with the consumer stalled.
    trig_en = 1'b0; rec_ready = 1'b0; got.delete();
    pulse_arm();
    for (int k = 0; k < 20; k++) bus(16'h0300 + 16'(k), 1'b0);
    check("t3.level", lvl[0], 5'd16);
    check("t3.ovf", ovf[0], 8'd4);
    check("t4.state", st[1], 2'd3);
    check("t4.done", dn[1], 1'b1);
    check("t4.level", lvl[1], 5'd16);
    check("t4.ovf", ovf[1], 8'd0);
    check("t5.level", lvl[2], 5'd3);
    check("t5.state", st[2], 2'd3);
    rec_ready = 1'b1;
    run(20);
    check("t3.drained", got.size(), 16);
    for (int k = 0; k < 16; k++) if (k < got.size())
      check($sformatf("t3.addr%0d", k), got[k][25:10], 16'h0300 + 16'(k));

    // T5b: arm while two records are pending clears the FIFO on the next clock.
    rec_ready = 1'b0;
    pulse_arm();
    bus(16'h0400, 1'b0);
    bus(16'h0401, 1'b0);
    check("t5.pending", lvl[2], 5'd2);
    arm = 1'b1; tick(); arm = 1'b0;
    check("t5.rearm_level", lvl[2], 5'd0);
    check("t5.rearm_state", st[2], 2'd1);

    // Overflow saturation and drops counting toward POST_COUNT.
    pulse_arm();
    sample_en = 1'b1;
    for (int k = 0; k < 280; k++) begin
      bus_addr = 16'(k); bus_data = 8'($urandom); tick();
    end
    sample_en = 1'b0;
    tick();
    check("sat.ovf", ovf[3], 8'hFF);
    check("post.ovf", ovf[0], 8'd48);
    check("post.state", st[0], 2'd3);
    rec_ready = 1'b1;
    run(20);

    // T6: asynchronous reset mid-capture.
    rec_ready = 1'b0;
    pulse_arm();
    sample_en = 1'b1;
    run(7);
    sample_en = 1'b0;
    check("t6.level", lvl[0], 5'd7);
    reset = 1'b1;
    #1;
    check("t6.state", st[0], 2'd0);
    check("t6.rlevel", lvl[0], 5'd0);
    check("t6.valid", vld[0], 1'b0);
    check("t6.data", rdat[0], 42'h0);
    check("t6.ovf", ovf[0], 8'd0);
    check("t6.done", dn[0], 1'b0);
    tick();
    reset = 1'b0; rec_ready = 1'b1; got.delete();
    pulse_arm();
    for (int k = 0; k < 3; k++) bus(16'h0500 + 16'(k), 1'b0);
    run(2);
    check("t6.count", got.size(), 3);
    if (got.size() > 2) check("t6.stamp2", got[2][41:26], 16'h2);

    // Randomized traffic against the model.
    hi_ready = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) hi_ready = 1 - hi_ready;
      arm       = ($urandom_range(0, 59) == 0);
      stop      = ($urandom_range(0, 89) == 0);
      sample_en = 1'($urandom);
      rec_ready = hi_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus_addr  = 16'h020E + 16'($urandom_range(0, 4));
      bus_sync  = 1'($urandom);
      bus_data  = 8'($urandom);
      bus_rw_n  = 1'($urandom);
      if (arm) trig_en = 1'($urandom);
      reset     = (c == 1500);
      tick();
    end
    reset = 1'b0; arm = 1'b0; stop = 1'b0; sample_en = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
